bit_serial_adder: RTL and testbench
===================================

Name: bit_serial_adder

Overview:
- Multi-bit adder that streams two WIDTH-bit operands LSB-first through a single full_adder instance, one bit per clock.
- A registered carry links successive bits.
- Sits directly upstream of, and drives, the existing 1-bit full_adder. It supplies a, b and cin each cycle and consumes sum and carry.
- Exposes a start/busy/done handshake to the surrounding datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when not busy
- op_a  input  WIDTH  operand A, captured on the accepted start
- op_b  input  WIDTH  operand B, captured on the accepted start
- cin  input  1  carry-in, captured on the accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  registered result, held until the next completion
- cout  output  1  registered final carry-out, held with sum

Behaviour:
- Reset is synchronous and active-high on clk.
  - While rst is high at an edge: state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry register and bit counter are cleared.
- Per-bit arithmetic is performed by one instantiated full_adder (ports a, b, cin, sum, carry); no other adder logic is allowed.
  - Its a = shift_a[0], b = shift_b[0], cin = carry register.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at edge E0: load shift_a=op_a, shift_b=op_b, carry_reg=cin, count=0 and go to SHIFT.
- SHIFT:
  - busy=1.
  - Each edge: carry_reg <= full_adder.carry.
  - Each edge: the accumulator shifts right with full_adder.sum entering at bit WIDTH-1.
  - Each edge: shift_a and shift_b shift right by one; count increments.
  - On the edge that processes bit WIDTH-1 (edge E_WIDTH):
    - sum <= completed accumulator.
    - cout <= full_adder.carry.
    - go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Next edge: if start=1, accept a new operation exactly as in IDLE (back-to-back). Otherwise go to IDLE.
- Latency:
  - busy is high for exactly WIDTH cycles after E0.
  - done is high in the cycle following E_WIDTH.
  - Throughput is one result per WIDTH+1 cycles.
- Result: {cout,sum} = op_a + op_b + cin, exact, no saturation; wrap-around is reported only via cout.
- sum and cout change only on completion or reset. They are stable and hold the previous result throughout SHIFT.
- start while busy=1 is ignored. It is not queued and does not disturb the current operation.
- op_a, op_b and cin are don't-care except at the accepting edge. Changes during SHIFT have no effect.
- rst during SHIFT aborts the operation: no done pulse; all outputs return to reset values on that edge.
- rst and start high together: rst wins; state remains IDLE.
- WIDTH=1: busy high for one cycle, then done.

Test Plan:
- WIDTH=8, op_a=0x00, op_b=0x00, cin=0, start pulse -> busy high 8 cycles, done pulse once, sum=0x00, cout=0.
- WIDTH=8, op_a=0x5A, op_b=0x3C, cin=0 -> sum=0x96, cout=0; 0xFF+0x01 cin=0 -> sum=0x00, cout=1; 0xFF+0xFF cin=1 -> sum=0xFF, cout=1.
- Start 0x12+0x34, then pulse start with op_a=0xFF, op_b=0xFF at cycle 3 of busy -> ignored; result sum=0x46, cout=0, exactly one done.
- Start 0x80+0x80 cin=1; in the DONE cycle hold start=1 with 0x01+0x02 cin=0:
  - first result sum=0x01, cout=1;
  - second operation begins immediately, giving sum=0x03, cout=0 exactly WIDTH+1 cycles after the first done.
- Start 0xAA+0x55, assert rst at busy cycle 4 -> busy=0, done never pulses, sum=0x00, cout=0; a subsequent 0x01+0x01 gives sum=0x02.
- WIDTH=3, all 128 combinations of op_a, op_b, cin -> {cout,sum} equals the arithmetic sum for every case; bench counts errors and reports pass/fail totals.

Source files
------------

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - LSB-first bit-serial adder driving a single 1-bit full_adder

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic            carry_reg;
  logic [CW-1:0]   count;
  logic [WIDTH-1:0] acc_next;
  logic            fa_sum;
  logic            fa_carry;
  logic            accept;
  logic            last_bit;

  // Idle and done cycles both accept a new request, which gives back-to-back operation
  assign accept   = ((state == IDLE) || (state == DONE)) && start;
  assign last_bit = (count == LAST);

  full_adder u_fa (
    .a     (shift_a[0]),
    .b     (shift_b[0]),
    .cin   (carry_reg),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Result bits enter at the MSB; after WIDTH shifts bit 0 of the result is at bit 0
  generate
    if (WIDTH == 1) begin : g_acc_one
      assign acc_next = fa_sum;
    end else begin : g_acc_wide
      logic [WIDTH-2:0] acc;
      assign acc_next = {fa_sum, acc};

      // Partial-result accumulator, cleared on accept so no stale bits leak in
      always_ff @(posedge clk) begin
        if (rst) begin
          acc <= '0;
        end else if (accept) begin
          acc <= '0;
        end else if (state == SHIFT) begin
          acc <= acc_next[WIDTH-1:1];
        end
      end
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (last_bit) next_state = DONE;
      DONE:    next_state = start ? SHIFT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Operand shifters, carry chain, bit counter and held result
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_a   <= '0;
      shift_b   <= '0;
      carry_reg <= 1'b0;
      count     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
    end else if (accept) begin
      shift_a   <= op_a;
      shift_b   <= op_b;
      carry_reg <= cin;
      count     <= '0;
    end else if (state == SHIFT) begin
      shift_a   <= shift_a >> 1;
      shift_b   <= shift_b >> 1;
      carry_reg <= fa_carry;
      count     <= count + CW'(1);
      if (last_bit) begin
        sum  <= acc_next;
        cout <= fa_carry;
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// tb/tb_bit_serial_adder.sv - self-checking bench for bit_serial_adder (WIDTH=8 and WIDTH=3)

module tb_bit_serial_adder;

  logic       clk;
  logic       rst;

  logic       start8;
  logic [7:0] op_a8;
  logic [7:0] op_b8;
  logic       cin8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start3;
  logic [2:0] op_a3;
  logic [2:0] op_b3;
  logic       cin3;
  logic       busy3;
  logic       done3;
  logic [2:0] sum3;
  logic       cout3;

  int total;
  int bad;
  int cyc;
  bit chk_en;

  bit_serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .op_a  (op_a8),
    .op_b  (op_b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  bit_serial_adder #(.WIDTH(3)) u_dut3 (
    .clk   (clk),
    .rst   (rst),
    .start (start3),
    .op_a  (op_a3),
    .op_b  (op_b3),
    .cin   (cin3),
    .busy  (busy3),
    .done  (done3),
    .sum   (sum3),
    .cout  (cout3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model for the 8-bit instance: an accepted request yields
  // a+b+cin after 8 busy cycles; requests while busy are dropped.
  int         m_rem;
  logic [8:0] m_pend;
  logic [8:0] m_res;
  logic       m_done;

  always @(posedge clk) begin
    if (rst) begin
      m_rem  <= 0;
      m_res  <= '0;
      m_done <= 1'b0;
    end else if (m_rem == 0 && start8) begin
      m_pend <= 9'(op_a8) + 9'(op_b8) + 9'(cin8);
      m_rem  <= 8;
      m_done <= 1'b0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_res  <= m_pend;
        m_done <= 1'b1;
      end else begin
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  // Cycle-by-cycle comparison of the 8-bit instance against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy8", 32'(busy8), 32'(m_rem > 0));
      check("done8", 32'(done8), 32'(m_done));
      check("result8", 32'({cout8, sum8}), 32'(m_res));
    end
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    start8 = 1'b1;
    op_a8  = a;
    op_b8  = b;
    cin8   = c;
    @(negedge clk);
    start8 = 1'b0;
    op_a8  = 8'($urandom);
    op_b8  = 8'($urandom);
    cin8   = 1'($urandom);
  endtask

  task automatic wait_done8(input string name, output int at);
    bit seen;
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (done8) begin
        seen = 1'b1;
        at   = cyc;
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s: timeout waiting for done, got none expected pulse", name);
    end
  endtask

  int t1;
  int t2;
  int nb;
  bit seen3;
  logic [3:0] exp3;

  initial begin
    total  = 0;
    bad    = 0;
    cyc    = 0;
    chk_en = 1'b0;
    rst    = 1'b1;
    start8 = 1'b0; op_a8 = '0; op_b8 = '0; cin8 = 1'b0;
    start3 = 1'b0; op_a3 = '0; op_b3 = '0; cin3 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy8), 32'd0);
    check("reset_done", 32'(done8), 32'd0);
    check("reset_sum", 32'({cout8, sum8}), 32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // zero operands, busy counted for 8 cycles
    issue8(8'h00, 8'h00, 1'b0);
    nb = 1;
    for (int i = 0; i < 20 && !done8; i++) begin
      @(negedge clk);
      if (busy8) nb++;
    end
    check("zero_busy_len", 32'(nb), 32'd8);
    check("zero_res", 32'({cout8, sum8}), 32'h000);

    issue8(8'h5A, 8'h3C, 1'b0);
    wait_done8("op_5a_3c", t1);
    check("lit_5a_3c", 32'({cout8, sum8}), 32'h096);

    issue8(8'hFF, 8'h01, 1'b0);
    wait_done8("op_ff_01", t1);
    check("lit_ff_01", 32'({cout8, sum8}), 32'h100);

    issue8(8'hFF, 8'hFF, 1'b1);
    wait_done8("op_ff_ff_1", t1);
    check("lit_ff_ff_1", 32'({cout8, sum8}), 32'h1FF);

    // start during busy is ignored
    issue8(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    start8 = 1'b1; op_a8 = 8'hFF; op_b8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8("op_12_34", t1);
    check("lit_12_34", 32'({cout8, sum8}), 32'h046);
    @(negedge clk);
    check("no_second_done", 32'(done8), 32'd0);

    // back-to-back: new request held during the done cycle
    issue8(8'h80, 8'h80, 1'b1);
    wait_done8("op_80_80", t1);
    check("lit_80_80_1", 32'({cout8, sum8}), 32'h101);
    start8 = 1'b1; op_a8 = 8'h01; op_b8 = 8'h02; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    check("b2b_busy", 32'(busy8), 32'd1);
    wait_done8("op_01_02", t2);
    check("lit_01_02", 32'({cout8, sum8}), 32'h003);
    check("b2b_spacing", 32'(t2 - t1), 32'd9);

    // reset mid-operation aborts with no done
    issue8(8'hAA, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_res", 32'({cout8, sum8}), 32'h000);
    repeat (10) begin
      @(negedge clk);
      check("abort_no_done", 32'(done8), 32'd0);
    end
    issue8(8'h01, 8'h01, 1'b0);
    wait_done8("op_01_01", t1);
    check("lit_01_01", 32'({cout8, sum8}), 32'h002);

    // rst and start together: rst wins
    @(negedge clk);
    rst = 1'b1; start8 = 1'b1;
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;
    check("rst_start_busy", 32'(busy8), 32'd0);

    // exhaustive WIDTH=3
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          start3 = 1'b1;
          op_a3  = 3'(a);
          op_b3  = 3'(b);
          cin3   = 1'(c);
          @(negedge clk);
          start3 = 1'b0;
          op_a3  = 3'($urandom);
          op_b3  = 3'($urandom);
          nb     = busy3 ? 1 : 0;
          seen3  = 1'b0;
          for (int i = 0; i < 10 && !seen3; i++) begin
            @(negedge clk);
            if (busy3) nb++;
            if (done3) seen3 = 1'b1;
          end
          exp3 = 4'(a + b + c);
          check("w3_busy_len", 32'(nb), 32'd3);
          check("w3_result", 32'({cout3, sum3}), 32'(exp3));
        end
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
